nano_prog_loader: RTL and testbench



---
 rtl/nano_loader_pkg.sv | 18 +
 rtl/nano_sync_edge.sv | 34 +++
 rtl/nano_prog_loader.sv | 174 +++++++++++++++++
 tb/tb_nano_prog_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_loader_pkg.sv
// Shared definitions for the Nano119 program loader.
//   loader_state_t : loader FSM states
//   NIBBLE_W       : width of one host nibble
//   SYNC_STAGES    : flops in each pin synchronizer
package nano_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      FULL,
      RUN
   } loader_state_t;

   localparam int unsigned NIBBLE_W    = 4;
   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/nano_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a rising-edge detector.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears every stage
//   din   : asynchronous pin
//   level : synchronized level of din
//   rise  : one-cycle pulse when level goes 0 -> 1
module nano_sync_edge
   import nano_loader_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;

endmodule

// File: rtl/nano_prog_loader.sv
// Pin-level program loader for the Nano119 CPU. The host streams nibbles
// (MSB-first) on ld_nibble with a strobe; complete words are written to
// consecutive program memory addresses while the CPU is held in reset.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ld_mode             : host load-mode request (async pin)
//   ld_strobe           : host nibble strobe (async pin), data taken on rise
//   ld_nibble           : host nibble data
//   mem_we/addr/wdata   : program memory write port (registered, 1-cycle we)
//   cpu_rst_n           : active-low CPU reset, released only in RUN
//   ld_count            : words written in the current load session
//   ld_err              : sticky error (partial word dropped / strobe while full)
//   ld_busy             : high in LOAD, WRITE and FULL
module nano_prog_loader
   import nano_loader_pkg::*;
#(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld_mode,
   input  logic                ld_strobe,
   input  logic [NIBBLE_W-1:0] ld_nibble,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [WORD_W-1:0]   mem_wdata,
   output logic                cpu_rst_n,
   output logic [ADDR_W:0]     ld_count,
   output logic                ld_err,
   output logic                ld_busy
);

   localparam int unsigned NIB_PER_WORD = WORD_W / NIBBLE_W;
   localparam int unsigned NIB_CNT_W    = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;
   localparam logic [NIB_CNT_W-1:0] LAST_NIB = NIB_CNT_W'(NIB_PER_WORD - 1);

   loader_state_t        state;
   logic [ADDR_W-1:0]    addr_q;
   logic [NIB_CNT_W-1:0] nib_cnt_q;
   logic [WORD_W-1:0]    asm_q;
   logic [WORD_W-1:0]    asm_shift;

   logic mode_s;
   logic mode_rise_unused;
   logic strobe_edge;
   logic strobe_s_unused;

   nano_sync_edge u_sync_mode (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (ld_mode),
      .level (mode_s),
      .rise  (mode_rise_unused)
   );

   nano_sync_edge u_sync_strobe (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (ld_strobe),
      .level (strobe_s_unused),
      .rise  (strobe_edge)
   );

   // New nibble enters at the bottom so the first one ends up in the top bits.
   always_comb begin
      asm_shift = (asm_q << NIBBLE_W) | WORD_W'(ld_nibble);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         nib_cnt_q <= '0;
         asm_q     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rst_n <= 1'b0;
         ld_count  <= '0;
         ld_err    <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            IDLE: begin
               cpu_rst_n <= 1'b0;
               if (mode_s) begin
                  state     <= LOAD;
                  addr_q    <= '0;
                  nib_cnt_q <= '0;
                  ld_count  <= '0;
                  ld_err    <= 1'b0;
               end else begin
                  state <= RUN;
               end
            end

            LOAD: begin
               cpu_rst_n <= 1'b0;
               // A mode fall wins over a coincident strobe edge.
               if (!mode_s) begin
                  if (nib_cnt_q != '0) begin
                     ld_err <= 1'b1;
                  end
                  nib_cnt_q <= '0;
                  state     <= RUN;
               end else if (strobe_edge) begin
                  asm_q <= asm_shift;
                  if (nib_cnt_q == LAST_NIB) begin
                     nib_cnt_q <= '0;
                     mem_we    <= 1'b1;
                     mem_addr  <= addr_q;
                     mem_wdata <= asm_shift;
                     state     <= WRITE;
                  end else begin
                     nib_cnt_q <= nib_cnt_q + NIB_CNT_W'(1);
                  end
               end
            end

            WRITE: begin
               cpu_rst_n <= 1'b0;
               ld_count  <= ld_count + (ADDR_W + 1)'(1);
               if (&addr_q) begin
                  // Out of room: a stray strobe here counts as a strobe while full.
                  if (strobe_edge) begin
                     ld_err <= 1'b1;
                  end
                  state <= FULL;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
                  // A stray edge here is kept as the first nibble of the next word.
                  if (strobe_edge) begin
                     asm_q     <= asm_shift;
                     nib_cnt_q <= NIB_CNT_W'(1);
                  end
                  state <= LOAD;
               end
            end

            FULL: begin
               cpu_rst_n <= 1'b0;
               if (strobe_edge) begin
                  ld_err <= 1'b1;
               end
               if (!mode_s) begin
                  state <= RUN;
               end
            end

            RUN: begin
               if (mode_s) begin
                  cpu_rst_n <= 1'b0;
                  state     <= LOAD;
                  addr_q    <= '0;
                  nib_cnt_q <= '0;
                  ld_count  <= '0;
                  ld_err    <= 1'b0;
               end else begin
                  cpu_rst_n <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               cpu_rst_n <= 1'b0;
            end
         endcase
      end
   end

   assign ld_busy = (state == LOAD) || (state == WRITE) || (state == FULL);

endmodule

// File: tb/tb_nano_prog_loader.sv
module tb_nano_prog_loader;

   localparam int WORD_W = 8;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst_n;
   logic              ld_mode;
   logic              ld_strobe;
   logic [3:0]        ld_nibble;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              cpu_rst_n;
   logic [ADDR_W:0]   ld_count;
   logic              ld_err;
   logic              ld_busy;

   int checks   = 0;
   int failures = 0;
   int writes   = 0;

   logic [ADDR_W+WORD_W-1:0] exp_q[$];

   nano_prog_loader #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_mode   (ld_mode),
      .ld_strobe (ld_strobe),
      .ld_nibble (ld_nibble),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .ld_count  (ld_count),
      .ld_err    (ld_err),
      .ld_busy   (ld_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         logic [ADDR_W+WORD_W-1:0] exp;
         writes++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write got addr=%0h data=%0h, expected no write",
                     mem_addr, mem_wdata);
         end else begin
            exp = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== exp) begin
               failures++;
               $display("FAIL write_data got addr=%0h data=%0h, expected addr=%0h data=%0h",
                        mem_addr, mem_wdata, exp[ADDR_W+WORD_W-1:WORD_W], exp[WORD_W-1:0]);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic send_nibble(input logic [3:0] n);
      @(negedge clk);
      ld_nibble = n;
      @(negedge clk);
      ld_strobe = 1'b1;
      repeat (4) @(negedge clk);
      ld_strobe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic load_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
      exp_q.push_back({a, d});
      send_nibble(d[7:4]);
      send_nibble(d[3:0]);
   endtask

   task automatic set_mode(input logic v);
      @(negedge clk);
      ld_mode = v;
      repeat (6) @(negedge clk);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got %0d pending writes, expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      int seen;
      rst_n     = 1'b0;
      ld_mode   = 1'b0;
      ld_strobe = 1'b0;
      ld_nibble = 4'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, ld_count, ld_err, ld_busy} !== '0) begin
         failures++;
         $display("FAIL reset_values got we=%b addr=%0h data=%0h crst=%b cnt=%0d err=%b busy=%b, expected all 0",
                  mem_we, mem_addr, mem_wdata, cpu_rst_n, ld_count, ld_err, ld_busy);
      end
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4 && seen == 0; i++) begin
         @(negedge clk);
         if (cpu_rst_n === 1'b1) seen = 1;
      end
      checks++;
      if (seen != 1) begin
         failures++;
         $display("FAIL reset_run_release got cpu_rst_n=%b, expected 1 within 4 clk", cpu_rst_n);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({ld_busy, ld_count, ld_err} !== '0) begin
         failures++;
         $display("FAIL reset_run_idle got busy=%b cnt=%0d err=%b, expected 0 0 0",
                  ld_busy, ld_count, ld_err);
      end
   endtask

   task automatic test_two_words();
      set_mode(1'b1);
      checks++;
      if (ld_busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
         failures++;
         $display("FAIL two_enter_load got busy=%b crst=%b, expected 1 0", ld_busy, cpu_rst_n);
      end
      load_word(4'd0, 8'hA5);
      load_word(4'd1, 8'h3C);
      wait_drain("two");
      checks++;
      if (ld_count !== 5'd2 || ld_err !== 1'b0) begin
         failures++;
         $display("FAIL two_count got cnt=%0d err=%b, expected 2 0", ld_count, ld_err);
      end
      set_mode(1'b0);
      checks++;
      if (cpu_rst_n !== 1'b1 || ld_busy !== 1'b0) begin
         failures++;
         $display("FAIL two_run got crst=%b busy=%b, expected 1 0", cpu_rst_n, ld_busy);
      end
   endtask

   task automatic test_full();
      int w0;
      set_mode(1'b1);
      w0 = writes;
      for (int i = 0; i < 16; i++) load_word(ADDR_W'(i), WORD_W'(i));
      wait_drain("full");
      checks++;
      if (ld_count !== 5'd16 || ld_busy !== 1'b1 || ld_err !== 1'b0) begin
         failures++;
         $display("FAIL full_state got cnt=%0d busy=%b err=%b, expected 16 1 0",
                  ld_count, ld_busy, ld_err);
      end
      send_nibble(4'hF);
      repeat (4) @(negedge clk);
      checks++;
      if (ld_err !== 1'b1 || ld_count !== 5'd16) begin
         failures++;
         $display("FAIL full_overflow got err=%b cnt=%0d, expected 1 16", ld_err, ld_count);
      end
      checks++;
      if (writes - w0 != 16) begin
         failures++;
         $display("FAIL full_write_count got %0d writes, expected 16", writes - w0);
      end
      set_mode(1'b0);
      checks++;
      if (cpu_rst_n !== 1'b1 || ld_err !== 1'b1) begin
         failures++;
         $display("FAIL full_exit got crst=%b err=%b, expected 1 1", cpu_rst_n, ld_err);
      end
   endtask

   task automatic test_partial();
      set_mode(1'b1);
      checks++;
      if (ld_err !== 1'b0 || ld_count !== 5'd0) begin
         failures++;
         $display("FAIL partial_session_clear got err=%b cnt=%0d, expected 0 0", ld_err, ld_count);
      end
      send_nibble(4'h7);
      set_mode(1'b0);
      checks++;
      if (ld_err !== 1'b1 || ld_busy !== 1'b0 || cpu_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL partial_discard got err=%b busy=%b crst=%b, expected 1 0 1",
                  ld_err, ld_busy, cpu_rst_n);
      end
   endtask

   task automatic test_reload();
      int seen;
      @(negedge clk);
      ld_mode = 1'b1;
      seen = 0;
      for (int i = 0; i < 3 && seen == 0; i++) begin
         @(negedge clk);
         if (cpu_rst_n === 1'b0) seen = 1;
      end
      checks++;
      if (seen != 1) begin
         failures++;
         $display("FAIL reload_cpu_hold got cpu_rst_n=%b, expected 0 within 3 clk", cpu_rst_n);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ld_err !== 1'b0 || ld_busy !== 1'b1) begin
         failures++;
         $display("FAIL reload_clear got err=%b busy=%b, expected 0 1", ld_err, ld_busy);
      end
      load_word(4'd0, 8'hE1);
      wait_drain("reload");
      checks++;
      if (ld_count !== 5'd1) begin
         failures++;
         $display("FAIL reload_count got %0d, expected 1", ld_count);
      end
   endtask

   task automatic test_reset_mid();
      send_nibble(4'h9);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, ld_count, ld_err, ld_busy} !== '0) begin
         failures++;
         $display("FAIL midreset_values got we=%b addr=%0h data=%0h crst=%b cnt=%0d err=%b busy=%b, expected all 0",
                  mem_we, mem_addr, mem_wdata, cpu_rst_n, ld_count, ld_err, ld_busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (ld_busy !== 1'b1) begin
         failures++;
         $display("FAIL midreset_reenter got busy=%b, expected 1", ld_busy);
      end
      load_word(4'd0, 8'h4B);
      wait_drain("midreset");
      checks++;
      if (ld_count !== 5'd1 || ld_err !== 1'b0) begin
         failures++;
         $display("FAIL midreset_count got cnt=%0d err=%b, expected 1 0", ld_count, ld_err);
      end
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_full();
      test_partial();
      test_reload();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
